// File: rtl/vt52_pkg.sv
//==============================================================================
// Module   : vt52_pkg
// Brief    : Screen geometry, control codes and FSM encoding for console_writer.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package vt52_pkg;

    localparam int          COLS       = 80;
    localparam int          ROWS       = 25;
    localparam int          ADDR_W     = 11;
    localparam logic [7:0]  CLEAR_CHAR = 8'h20;

    localparam logic [7:0]  CODE_CR    = 8'h0D;
    localparam logic [7:0]  CODE_LF    = 8'h0A;
    localparam logic [7:0]  CODE_BS    = 8'h08;

    typedef enum logic [1:0] {
        ST_INIT_CLEAR = 2'd0,
        ST_IDLE       = 2'd1,
        ST_WRITE      = 2'd2,
        ST_SCROLL     = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/char_addr_calc.sv
//==============================================================================
// Module   : char_addr_calc
// Brief    : Maps (top_row, logical row, col) to a char_buffer address.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module char_addr_calc
    import vt52_pkg::*;
(
    input  logic [4:0]        top_row,
    input  logic [4:0]        row,
    input  logic [6:0]        col,
    output logic [ADDR_W-1:0] addr
);

    logic [5:0]        w_sum;
    logic [4:0]        w_phys;
    logic [ADDR_W-1:0] w_p;

    // Inputs are both < ROWS, so a single conditional subtract completes the modulo.
    always_comb begin
        w_sum  = {1'b0, top_row} + {1'b0, row};
        w_phys = (w_sum >= 6'(ROWS)) ? 5'(w_sum - 6'(ROWS)) : w_sum[4:0];
        w_p    = ADDR_W'(w_phys);
        addr   = (w_p << 6) + (w_p << 4) + ADDR_W'(col);
    end

endmodule

`default_nettype wire

// File: rtl/console_writer.sv
//==============================================================================
// Module   : console_writer
// Brief    : Owns the char_buffer port; clears, prints, moves cursor, scrolls.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module console_writer
    import vt52_pkg::*;
(
    input  logic              clk,
    input  logic              clr_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              fetch_active,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [7:0]        buf_din,
    output logic              buf_wen,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic [4:0]        top_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(COLS*ROWS-1);
    localparam logic [6:0]        c_last_col  = 7'(COLS-1);
    localparam logic [4:0]        c_last_row  = 5'(ROWS-1);

    state_t            r_state;
    logic [6:0]        r_col;
    logic [4:0]        r_row;
    logic [4:0]        r_top;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [6:0]        r_scol;
    logic [7:0]        r_din;
    logic              r_run;

    logic              w_wr_req;
    logic              w_commit;
    logic [4:0]        w_calc_row;
    logic [6:0]        w_calc_col;
    logic [ADDR_W-1:0] w_calc_addr;
    logic [ADDR_W-1:0] w_wr_addr;

    // Scroll clears the physical row at top_row, i.e. logical row 0.
    assign w_calc_row = (r_state == ST_SCROLL) ? 5'd0 : r_row;
    assign w_calc_col = (r_state == ST_SCROLL) ? r_scol : r_col;

    char_addr_calc u_addr_calc (
        .top_row (r_top),
        .row     (w_calc_row),
        .col     (w_calc_col),
        .addr    (w_calc_addr)
    );

    // r_run keeps buf_wen low in the reset state and the first cycle after release.
    always_comb begin
        w_wr_req  = 1'b0;
        w_wr_addr = w_calc_addr;
        case (r_state)
            ST_INIT_CLEAR: begin
                w_wr_req  = r_run;
                w_wr_addr = r_clr_cnt;
            end
            ST_WRITE, ST_SCROLL: w_wr_req = 1'b1;
            default:             w_wr_req = 1'b0;
        endcase
    end

    assign w_commit   = w_wr_req & ~fetch_active;
    assign buf_wen    = w_commit;
    assign buf_addr   = fetch_active ? fetch_addr : w_wr_addr;
    assign buf_din    = r_din;
    assign in_ready   = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign top_row    = r_top;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state   <= ST_INIT_CLEAR;
            r_col     <= '0;
            r_row     <= '0;
            r_top     <= '0;
            r_clr_cnt <= '0;
            r_scol    <= '0;
            r_din     <= CLEAR_CHAR;
            r_run     <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                ST_INIT_CLEAR: begin
                    if (w_commit) begin
                        if (r_clr_cnt == c_last_addr) begin
                            r_clr_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_clr_cnt <= r_clr_cnt + 1'b1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (in_valid) begin
                        if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                            r_din   <= in_data;
                            r_state <= ST_WRITE;
                        end else if (in_data == CODE_CR) begin
                            r_col <= '0;
                        end else if (in_data == CODE_BS) begin
                            if (r_col != 7'd0) r_col <= r_col - 1'b1;
                        end else if (in_data == CODE_LF) begin
                            if (r_row < c_last_row) begin
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_scol  <= '0;
                                r_state <= ST_SCROLL;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    // No autowrap: the last column is overwritten by further bytes.
                    if (w_commit) begin
                        if (r_col < c_last_col) r_col <= r_col + 1'b1;
                        r_din   <= CLEAR_CHAR;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCROLL: begin
                    if (w_commit) begin
                        if (r_scol == c_last_col) begin
                            r_top   <= (r_top == c_last_row) ? 5'd0 : r_top + 1'b1;
                            r_scol  <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_scol <= r_scol + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_INIT_CLEAR;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_console_writer.sv
//==============================================================================
// Module   : tb_console_writer
// Brief    : Scoreboard bench for console_writer buffer writes and cursor state.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_console_writer;

    logic        clk;
    logic        clr_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        fetch_active;
    logic [10:0] fetch_addr;
    logic [10:0] buf_addr;
    logic [7:0]  buf_din;
    logic        buf_wen;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic [4:0]  top_row;
    logic        busy;

    console_writer dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .fetch_active (fetch_active),
        .fetch_addr   (fetch_addr),
        .buf_addr     (buf_addr),
        .buf_din      (buf_din),
        .buf_wen      (buf_wen),
        .cursor_col   (cursor_col),
        .cursor_row   (cursor_row),
        .top_row      (top_row),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    logic [18:0] exp_q[$];   // {addr[10:0], data[7:0]}

    int m_col = 0;
    int m_row = 0;
    int m_top = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every committed write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (clr_n && buf_wen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {13'd0, buf_addr, buf_din}, 32'h7FFFF);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                check("buf_write", {13'd0, buf_addr, buf_din}, {13'd0, e});
            end
        end
    end

    function automatic void push_clear_all();
        for (int a = 0; a < 2000; a++) exp_q.push_back({11'(a), 8'h20});
    endfunction

    // Reference model of how a byte changes the cursor and what it writes.
    function automatic void model_byte(logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            exp_q.push_back({11'(((m_top + m_row) % 25) * 80 + m_col), b});
            if (m_col < 79) m_col++;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0A) begin
            if (m_row < 24) m_row++;
            else begin
                for (int c = 0; c < 80; c++) exp_q.push_back({11'(m_top * 80 + c), 8'h20});
                m_top = (m_top + 1) % 25;
            end
        end
    endfunction

    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_ready(300);
        model_byte(b);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic check_cursor(string name);
        wait_ready(300);
        check({name, "_col"}, {25'd0, cursor_col}, 32'(m_col));
        check({name, "_row"}, {27'd0, cursor_row}, 32'(m_row));
        check({name, "_top"}, {27'd0, top_row}, 32'(m_top));
    endtask

    task automatic check_reset_outputs(string name);
        check({name, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        check({name, "_wen"}, {31'd0, buf_wen}, 32'd0);
        check({name, "_din"}, {24'd0, buf_din}, 32'h20);
        check({name, "_col"}, {25'd0, cursor_col}, 32'd0);
        check({name, "_row"}, {27'd0, cursor_row}, 32'd0);
        check({name, "_top"}, {27'd0, top_row}, 32'd0);
    endtask

    initial begin
        clr_n        = 1'b0;
        in_data      = 8'h00;
        in_valid     = 1'b0;
        fetch_active = 1'b0;
        fetch_addr   = 11'd0;

        // 1: reset state, then full clear of 0..1999
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        push_clear_all();
        clr_n = 1'b1;
        wait_ready(2100);
        check("init_clear_drained", 32'(exp_q.size()), 32'd0);
        check_cursor("after_init");

        // 2: printable byte held off by video fetch
        fetch_active = 1'b1;
        fetch_addr   = 11'd100;
        send_byte(8'h41);
        for (int i = 0; i < 10; i++) begin
            fetch_addr = 11'(100 + i);
            @(negedge clk);
            check("fetch_wen", {31'd0, buf_wen}, 32'd0);
            check("fetch_addr", {21'd0, buf_addr}, 32'(100 + i));
        end
        check("held_write_pending", 32'(exp_q.size()), 32'd1);
        fetch_active = 1'b0;
        check_cursor("after_A");

        // 3: fill to col 79, then two bytes land on the last column
        for (int i = 0; i < 78; i++) send_byte(8'(8'h30 + (i % 10)));
        check_cursor("at_col79");
        send_byte(8'h5A);
        send_byte(8'h59);
        check_cursor("after_ZY");

        // 4: move to bottom row, LF scrolls, then CR + 'B' lands at addr 0
        for (int i = 0; i < 24; i++) send_byte(8'h0A);
        check_cursor("bottom");
        send_byte(8'h0A);
        check_cursor("after_scroll");
        send_byte(8'h0D);
        send_byte(8'h42);
        check_cursor("after_B");

        // 5: CR, BS at both boundaries, ignored control byte
        for (int i = 0; i < 39; i++) send_byte(8'h61);
        check_cursor("col40");
        send_byte(8'h0D);
        check_cursor("cr");
        send_byte(8'h08);
        check_cursor("bs_at0");
        for (int i = 0; i < 5; i++) send_byte(8'h62);
        send_byte(8'h08);
        check_cursor("bs_at5");
        send_byte(8'h1B);
        check_cursor("esc_ignored");
        repeat (4) @(negedge clk);
        check("no_pending_writes", 32'(exp_q.size()), 32'd0);

        // 6: reset in the middle of a scroll
        send_byte(8'h0A);
        repeat (20) @(posedge clk);
        #2 clr_n = 1'b0;
        #1 check_reset_outputs("mid_scroll_reset");
        exp_q.delete();
        m_col = 0; m_row = 0; m_top = 0;
        repeat (3) @(negedge clk);
        check("reset_hold_wen", {31'd0, buf_wen}, 32'd0);
        push_clear_all();
        clr_n = 1'b1;
        wait_ready(2100);
        check("reclear_drained", 32'(exp_q.size()), 32'd0);
        check_cursor("after_reclear");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
